// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state width and encodings.
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell processes one operand bit per clock,
// LSB first, producing a registered WIDTH-bit sum and carry-out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d, sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fa_s, fa_cout;
  logic               last_c;
  logic [WIDTH-1:0]   res_shift_c;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Counter holds the number of bits already consumed; this edge is the last bit.
  assign last_c      = (cnt_q == CNT_W'(WIDTH - 1));
  assign res_shift_c = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_c) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = (state_d == ST_SHIFT);
    done_d  = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        res_d   = res_shift_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          sum_d  = res_shift_c;
          cout_d = fa_cout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 1-bit instance checked
// against plain integer addition.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, start1, cin1;
  logic [7:0] a8, b8, sum8;
  logic [0:0] a1, b1, sum1;
  logic       busy8, done8, cout8, busy1, done1, cout1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prev_sum8;
  logic       prev_cout8;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit addition; optional stray start mid-flight or reset abort at SHIFT cycle 4.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input bit second, input bit abort);
    logic [8:0] expv;
    int done_at;
    int pulses;
    bit aborted;
    expv    = 9'(ta) + 9'(tb) + 9'(tc);
    done_at = -1;
    pulses  = 0;
    aborted = 1'b0;
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) tick();
      if (second && n == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; end
      if (second && n == 4) start8 = 1'b0;
      if (abort && n == 4) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum",  32'(sum8),  32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        prev_sum8 = 8'h00; prev_cout8 = 1'b0;
        #2 rst = 1'b0;
        aborted = 1'b1;
      end
      chk("busy_done_excl", 32'(busy8 & done8), 32'd0);
      if (!aborted) chk("busy_window", 32'(busy8), 32'(n >= 1 && n <= 8));
      if (busy8) begin
        chk("sum_hold",  32'(sum8),  32'(prev_sum8));
        chk("cout_hold", 32'(cout8), 32'(prev_cout8));
      end
      if (done8) begin
        pulses++;
        if (done_at < 0) done_at = n;
      end
    end
    if (aborted) begin
      chk("abort_no_done", 32'(pulses), 32'd0);
      chk("abort_sum",     32'(sum8),   32'd0);
    end else begin
      chk("done_latency", 32'(done_at), 32'd9);
      chk("done_pulses",  32'(pulses),  32'd1);
      chk("sum8",  32'(sum8),  32'(expv[7:0]));
      chk("cout8", 32'(cout8), 32'(expv[8]));
      prev_sum8  = expv[7:0];
      prev_cout8 = expv[8];
    end
  endtask

  task automatic run1(input logic ta, input logic tb, input logic tc);
    logic [1:0] expv;
    int done_at;
    expv    = 2'(ta) + 2'(tb) + 2'(tc);
    done_at = -1;
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) tick();
      chk("w1_excl", 32'(busy1 & done1), 32'd0);
      if (done1 && done_at < 0) done_at = n;
    end
    chk("w1_latency", 32'(done_at), 32'd2);
    chk("w1_result",  32'({cout1, sum1}), 32'(expv));
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    prev_sum8 = 8'h00; prev_cout8 = 1'b0;
    #1;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_sum",  32'(sum8),  32'd0);
    chk("reset_cout", 32'(cout8), 32'd0);
    chk("reset_w1",   32'({busy1, done1, cout1, sum1}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    run8(8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0);
    run8(8'h3C, 8'h4D, 1'b1, 1'b1, 1'b0);
    run8(8'h77, 8'h99, 1'b0, 1'b0, 1'b1);
    run8(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run1(v[2], v[1], v[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: Parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005: a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006: b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007: cin  input  1  carry-in; captured on the accepted start edge.
REQ-008: busy  output  1  high while bits are being processed (state SHIFT).
REQ-009: done  output  1  one-cycle pulse; sum and cout are valid for the new result.
REQ-010: sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011: cout  output  1  registered carry-out of the full WIDTH-bit addition.

Function
REQ-012: The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013: In IDLE with start=1 at an edge, the block SHALL load a, b and cin into internal operand shift registers and a carry register, clear the bit counter, and enter SHIFT.
REQ-014: In SHIFT, each edge SHALL add bit 0 of each operand register and the carry register through one full_adder cell.
REQ-015: At each SHIFT edge, the sum bit SHALL shift into the MSB of the result shift register, the operands SHALL shift right by one bit, the carry register SHALL take the cell's carry-out, and the counter SHALL increment.
REQ-016: On the WIDTH-th SHIFT edge, the block SHALL copy the result shift register to sum and the final carry to cout, then enter DONE.
REQ-017: DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018: Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH; busy SHALL be high from edge k to edge k+WIDTH.
REQ-019: start SHALL be ignored in SHIFT and DONE; a start held high through DONE is accepted at the first IDLE edge.
REQ-020: sum and cout SHALL hold the last completed result until the next completion and SHALL NOT change during SHIFT.
REQ-021: Changes to a, b or cin after the accepted start edge SHALL NOT affect the result in flight.
REQ-022: For WIDTH=1, exactly one SHIFT cycle SHALL occur and cout SHALL equal the carry of a[0]+b[0]+cin.
REQ-023: The counter width SHALL be clog2(WIDTH+1) bits; the counter SHALL NOT wrap within an operation.
REQ-024: busy and done SHALL never be high in the same cycle.

Reset
REQ-025: rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and shift registers, regardless of clk.
REQ-026: Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Structure
REQ-027: FSM state encodings (IDLE=0, SHIFT=1, DONE=2, 2 bits) SHALL be constants in shared package serial_adder_pkg; no other shared typedefs are required.
REQ-028: The bit-level add SHALL be one instance of the existing full_adder sub-module (ports a, b, cin, s, cout); no other sub-modules.
REQ-029: The implementation SHALL contain no combinational path from start, a, b or cin to any output.

Verification
REQ-030: WIDTH=8, a=0x00, b=0x00, cin=0, start pulse -> done exactly 9 cycles after the start edge; sum=0x00, cout=0.
REQ-031: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032: a=0xA5, b=0x5A, cin=0 -> sum=0xFF, cout=0; sum holds the prior result throughout busy.
REQ-033: Second start pulsed at cycle 3 of busy with a=0x11, b=0x22 -> ignored; the first result completes unchanged and exactly one done pulse occurs.
REQ-034: rst asserted at cycle 4 of SHIFT -> busy, done, sum and cout drop to 0 immediately with no done pulse; a following start with a=0x03, b=0x04 -> sum=0x07, cout=0.
REQ-035: WIDTH=1 exhaustive sweep of all 8 combinations of a, b, cin -> {cout,sum} equals the arithmetic sum in every case; done arrives 2 cycles after each accepted start.
